// File: rtl/random_roller.sv
// random_roller: free-running Galois LFSR with single-shot and decelerating "roll" draws.
// Latency: single-shot result 1 cycle after the start edge; roll step k lands BASE_DIV*k(k+1)/2 edges after acceptance.
// Backpressure: none; i_start is level-sampled and ignored while rolling unless RAND_RESTART_EN is defined.
//
// Optional feature macro: RAND_RESTART_EN (i_start during a roll restarts it).
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start, i_mode   draw request (level) and draw mode (0 single-shot, 1 roll)
//   i_seed_load,i_seed run-time LFSR seed (zero seed replaced by SEED)
//   o_random_out      last drawn value, held between updates
//   o_valid, o_done   1-cycle pulses on every update / on the final update of a draw
//   o_busy            high while a roll is in progress
module random_roller #(
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int                OUT_W    = 4,
  parameter int                N_STEPS  = 8,
  parameter int                BASE_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [OUT_W-1:0]  o_random_out,
  output logic              o_valid,
  output logic              o_done,
  output logic              o_busy
);

  localparam int CNT_W  = $clog2(N_STEPS * BASE_DIV + 1);
  localparam int STEP_W = $clog2(N_STEPS + 1);

  typedef enum logic {IDLE, ROLL} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               valid_d, done_d;
  logic [OUT_W-1:0]   sample;

  // Draws always take the pre-edge LFSR value, so a same-edge seed load
  // only affects later draws.
  assign sample = lfsr_q[OUT_W-1:0];

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    if (i_seed_load) begin
      // An all-zero state would lock the LFSR, so substitute the reset seed.
      lfsr_d = (i_seed == '0) ? SEED : i_seed;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (!i_mode) begin
            out_d   = sample;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ROLL;
            step_d  = STEP_W'(1);
            cnt_d   = CNT_W'(BASE_DIV - 1);
          end
        end
      end
      ROLL: begin
`ifdef RAND_RESTART_EN
        // Restart beats everything else this edge, including a final step.
        if (i_start) begin
          step_d = STEP_W'(1);
          cnt_d  = CNT_W'(BASE_DIV - 1);
        end else
`endif
        if (cnt_q == '0) begin
          out_d   = sample;
          valid_d = 1'b1;
          if (step_q < STEP_W'(N_STEPS)) begin
            step_d = step_q + 1'b1;
            // Step k lasts k*BASE_DIV edges; the counter runs k*BASE_DIV-1 down to 0.
            cnt_d  = CNT_W'((int'(step_q) + 1) * BASE_DIV - 1);
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            step_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      step_q  <= '0;
      out_q   <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      out_q   <= out_d;
      o_valid <= valid_d;
      o_done  <= done_d;
    end
  end

  assign o_random_out = out_q;
  assign o_busy       = (state_q == ROLL);

endmodule

// File: tb/tb_random_roller.sv
module tb_random_roller;

  localparam int               LFSR_W   = 16;
  localparam logic [15:0]      TAPS     = 16'hB400;
  localparam logic [15:0]      SEED     = 16'hACE1;
  localparam int               OUT_W    = 4;
  localparam int               N_STEPS  = 8;
  localparam int               BASE_DIV = 4;
  localparam int               ROLL_LEN = BASE_DIV * N_STEPS * (N_STEPS + 1) / 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic [OUT_W-1:0]  random_out;
  logic              valid;
  logic              done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Reference model state (spec-level view: elapsed time since acceptance).
  logic [LFSR_W-1:0] m_lfsr;
  logic [OUT_W-1:0]  m_out;
  logic              m_valid, m_done, m_busy;
  int                m_t;

  random_roller #(
    .LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED),
    .OUT_W(OUT_W), .N_STEPS(N_STEPS), .BASE_DIV(BASE_DIV)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_seed_load(seed_load), .i_seed(seed),
    .o_random_out(random_out), .o_valid(valid), .o_done(done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  // Which roll step (1..N) lands exactly t edges after acceptance, or 0.
  function automatic int step_at(input int t);
    for (int k = 1; k <= N_STEPS; k++)
      if (BASE_DIV * k * (k + 1) / 2 == t) return k;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_out = '0; m_valid = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_t = 0;
  endtask

  task automatic model_edge();
    logic [LFSR_W-1:0] pre;
    logic restart;
    int k;
    pre = m_lfsr;
    restart = 1'b0;
`ifdef RAND_RESTART_EN
    restart = start;
`endif
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_lfsr  = seed_load ? ((seed == '0) ? SEED : seed) : lfsr_next(m_lfsr);
    if (!m_busy) begin
      if (start) begin
        if (!mode) begin
          m_out = pre[OUT_W-1:0]; m_valid = 1'b1; m_done = 1'b1;
        end else begin
          m_busy = 1'b1; m_t = 0;
        end
      end
    end else if (restart) begin
      m_t = 0;
    end else begin
      m_t++;
      k = step_at(m_t);
      if (k != 0) begin
        m_out = pre[OUT_W-1:0];
        m_valid = 1'b1;
        if (k == N_STEPS) begin
          m_done = 1'b1; m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic cmp_outputs(input string tag);
    check({tag, ".out"},   32'(random_out), 32'(m_out));
    check({tag, ".valid"}, 32'(valid),      32'(m_valid));
    check({tag, ".done"},  32'(done),       32'(m_done));
    check({tag, ".busy"},  32'(busy),       32'(m_busy));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    cmp_outputs(tag);
  endtask

  task automatic wait_idle();
    int n;
    start = 1'b0; seed_load = 1'b0;
    n = 0;
    while (m_busy && n < 300) begin
      tick("drain");
      n++;
    end
    check("idle_before_roll", 32'(busy), 32'd0);
  endtask

  // Start a roll and run 200 edges; poke start once at offset 'poke'.
  task automatic run_roll(input int poke, output int done_at, output int nval);
    done_at = -1;
    nval = 0;
    wait_idle();
    start = 1'b1; mode = 1'b1;
    tick("roll_e0");
    start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      start = (t == poke);
      mode  = 1'($urandom_range(1));
      tick("roll");
      if (valid) nval++;
      if (done && done_at < 0) done_at = t;
    end
    start = 1'b0;
  endtask

  initial begin
    int done_at, nval, exp_done, exp_nval;

    rst = 1'b1; start = 1'b0; mode = 1'b0; seed_load = 1'b0; seed = '0;
    model_reset();
    #12;
    cmp_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("idle");

    // Seed 1, then single-shot next edge -> 1; again one edge later -> 0 (lfsr = B400).
    seed_load = 1'b1; seed = 16'h0001; tick("seed1");
    seed_load = 1'b0; start = 1'b1; mode = 1'b0; tick("ss1");
    check("ss_seed1_value", 32'(random_out), 32'h1);
    check("ss_seed1_done",  32'(done),       32'h1);
    start = 1'b0; tick("ss1_after");
    check("ss1_valid_drop", 32'(valid), 32'h0);
    seed_load = 1'b1; seed = 16'h0001; tick("seed1b");
    seed_load = 1'b0; tick("adv");
    start = 1'b1; tick("ss2");
    check("ss_b400_value", 32'(random_out), 32'h0);
    start = 1'b0;
    // Zero seed substitutes SEED.
    seed_load = 1'b1; seed = 16'h0000; tick("seed0");
    seed_load = 1'b0; start = 1'b1; tick("ss3");
    check("ss_zero_seed_value", 32'(random_out), 32'h1);
    start = 1'b0; tick("ss3_after");

    // Random single-shot traffic with random seed loads.
    for (int i = 0; i < 300; i++) begin
      seed_load = ($urandom_range(7) == 0);
      seed      = ($urandom_range(5) == 0) ? 16'h0000 : 16'($urandom);
      start     = ($urandom_range(3) == 0);
      mode      = 1'b0;
      tick("rand_ss");
    end

    // Random mixed traffic including rolls and starts during rolls.
    for (int i = 0; i < 1500; i++) begin
      seed_load = ($urandom_range(15) == 0);
      seed      = ($urandom_range(5) == 0) ? 16'h0000 : 16'($urandom);
      start     = ($urandom_range(9) == 0);
      mode      = 1'($urandom_range(1));
      tick("rand_mix");
    end
    seed_load = 1'b0;

    // Directed roll with a start poke at E0+50.
    run_roll(50, done_at, nval);
`ifdef RAND_RESTART_EN
    exp_done = 50 + ROLL_LEN;
`else
    exp_done = ROLL_LEN;
`endif
    exp_nval = N_STEPS;
`ifdef RAND_RESTART_EN
    for (int k = 1; k <= N_STEPS; k++)
      if (BASE_DIV * k * (k + 1) / 2 < 50) exp_nval++;
`endif
    check("roll50_done_at", 32'(done_at), 32'(exp_done));
    check("roll50_nvalid",  32'(nval),    32'(exp_nval));

    // Restart poke at E0+30.
    run_roll(30, done_at, nval);
`ifdef RAND_RESTART_EN
    exp_done = 30 + ROLL_LEN;
`else
    exp_done = ROLL_LEN;
`endif
    check("roll30_done_at", 32'(done_at), 32'(exp_done));

    // Asynchronous reset mid-roll at E0+30.
    wait_idle();
    start = 1'b1; mode = 1'b1; tick("rst_e0");
    start = 1'b0;
    for (int t = 1; t <= 30; t++) tick("rst_roll");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.out",   32'(random_out), 32'h0);
    check("async_rst.valid", 32'(valid),      32'h0);
    check("async_rst.done",  32'(done),       32'h0);
    check("async_rst.busy",  32'(busy),       32'h0);
    model_reset();
    #1;
    rst = 1'b0;
    run_roll(0, done_at, nval);
    check("post_rst_done_at", 32'(done_at), 32'(ROLL_LEN));
    check("post_rst_nvalid",  32'(nval),    32'(N_STEPS));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
